// File: rtl/rgb2ycbcr_pipe_if.sv
// rgb2ycbcr_pipe_if: video stream bundle (syncs, RGB in, YCbCr out, mode control) for rgb2ycbcr_pipe
interface rgb2ycbcr_pipe_if #(parameter int R_W = 5, parameter int G_W = 6, parameter int B_W = 5);
  logic ce;
  logic mode;
  logic pre_vsync;
  logic pre_hsync;
  logic pre_de;
  logic [R_W-1:0] img_r;
  logic [G_W-1:0] img_g;
  logic [B_W-1:0] img_b;
  logic post_vsync;
  logic post_hsync;
  logic post_de;
  logic [7:0] img_y;
  logic [7:0] img_cb;
  logic [7:0] img_cr;
  logic mode_act;
  modport master (
    output ce, mode, pre_vsync, pre_hsync, pre_de, img_r, img_g, img_b,
    input post_vsync, post_hsync, post_de, img_y, img_cb, img_cr, mode_act
  );
  modport slave (
    input ce, mode, pre_vsync, pre_hsync, pre_de, img_r, img_g, img_b,
    output post_vsync, post_hsync, post_de, img_y, img_cb, img_cr, mode_act
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// rgb2ycbcr_pipe: 3-stage full-range RGB->YCbCr converter with ce stall; define RGB2YCBCR_BT709_EN for frame-locked BT.709 mode
module rgb2ycbcr_pipe #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5
) (
  input logic clk,
  input logic rst_n,
  rgb2ycbcr_pipe_if.slave bus
);
  localparam logic [71:0] K601 = {8'd21, 8'd107, 8'd128, 8'd128, 8'd85, 8'd43, 8'd29, 8'd150, 8'd77};
  logic [7:0] x8 [3];
  logic [15:0] p [9];
  logic [17:0] s [3];
  logic [7:0] y_q, cb_q, cr_q;
  logic [2:0] vs_d, hs_d, de_d;
  logic v1;
  logic mode_act_q;
  logic [71:0] k;
  if (R_W == 8) begin : g_r8
    assign x8[0] = bus.img_r;
  end else begin : g_rx
    assign x8[0] = {bus.img_r, bus.img_r[R_W-1 -: 8-R_W]};
  end
  if (G_W == 8) begin : g_g8
    assign x8[1] = bus.img_g;
  end else begin : g_gx
    assign x8[1] = {bus.img_g, bus.img_g[G_W-1 -: 8-G_W]};
  end
  if (B_W == 8) begin : g_b8
    assign x8[2] = bus.img_b;
  end else begin : g_bx
    assign x8[2] = {bus.img_b, bus.img_b[B_W-1 -: 8-B_W]};
  end
`ifdef RGB2YCBCR_BT709_EN
  localparam logic [71:0] K709 = {8'd12, 8'd116, 8'd128, 8'd128, 8'd99, 8'd29, 8'd19, 8'd183, 8'd54};
  logic vs_q;
  assign k = mode_act_q ? K709 : K601;
  // Load the coefficient set on a rising vsync so a frame never mixes sets
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_q <= 1'b0;
      mode_act_q <= 1'b0;
    end else if (bus.ce) begin
      vs_q <= bus.pre_vsync;
      if (bus.pre_vsync && !vs_q) mode_act_q <= bus.mode;
    end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
  assign k = K601;
  assign mode_act_q = 1'b0;
`endif
  function automatic logic [7:0] sat(input logic [17:0] v);
    return v[17] ? 8'd0 : v[16] ? 8'd255 : v[15:8];
  endfunction
  // Products, offset sums, saturated bytes and sync delay all advance together on ce;
  // v1 keeps sums of the reset-cleared products from reaching the output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) p[i] <= '0;
      for (int i = 0; i < 3; i++) s[i] <= '0;
      v1 <= 1'b0;
      y_q <= '0;
      cb_q <= '0;
      cr_q <= '0;
      vs_d <= '0;
      hs_d <= '0;
      de_d <= '0;
    end else if (bus.ce) begin
      v1 <= 1'b1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          p[3*i+j] <= 16'(x8[j]) * 16'(k[8*(3*i+j) +: 8]);
      s[0] <= v1 ? 18'(p[0]) + 18'(p[1]) + 18'(p[2]) + 18'd128 : '0;
      s[1] <= v1 ? 18'd32896 + 18'(p[5]) - 18'(p[3]) - 18'(p[4]) : '0;
      s[2] <= v1 ? 18'd32896 + 18'(p[6]) - 18'(p[7]) - 18'(p[8]) : '0;
      y_q <= sat(s[0]);
      cb_q <= sat(s[1]);
      cr_q <= sat(s[2]);
      vs_d <= {vs_d[1:0], bus.pre_vsync};
      hs_d <= {hs_d[1:0], bus.pre_hsync};
      de_d <= {de_d[1:0], bus.pre_de};
    end
  assign bus.img_y = y_q;
  assign bus.img_cb = cb_q;
  assign bus.img_cr = cr_q;
  assign bus.post_vsync = vs_d[2];
  assign bus.post_hsync = hs_d[2];
  assign bus.post_de = de_d[2];
  assign bus.mode_act = mode_act_q;
endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// tb_rgb2ycbcr_pipe: scoreboard bench for rgb2ycbcr_pipe (565 input) with directed and random-ce stimulus
module tb_rgb2ycbcr_pipe;
`ifdef RGB2YCBCR_BT709_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [26:0] q [$];
  logic [26:0] cur;
  logic m_act;
  logic pv;
  rgb2ycbcr_pipe_if #(.R_W(5), .G_W(6), .B_W(5)) bus ();
  rgb2ycbcr_pipe #(.R_W(5), .G_W(6), .B_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  wire [27:0] obs = {bus.post_vsync, bus.post_hsync, bus.post_de, bus.img_y, bus.img_cb, bus.img_cr, bus.mode_act};
  function automatic logic [7:0] sat(input int v);
    return v < 0 ? 8'd0 : v > 65535 ? 8'd255 : 8'(v >>> 8);
  endfunction
  function automatic logic [26:0] model(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b,
                                        input logic m, input logic v, input logic h, input logic d);
    int r8, g8, b8, y, cb, cr;
    r8 = int'({r, r[4:2]});
    g8 = int'({g, g[5:4]});
    b8 = int'({b, b[4:2]});
    if (m) begin
      y = 54 * r8 + 183 * g8 + 19 * b8;
      cb = -29 * r8 - 99 * g8 + 128 * b8;
      cr = 128 * r8 - 116 * g8 - 12 * b8;
    end else begin
      y = 77 * r8 + 150 * g8 + 29 * b8;
      cb = -43 * r8 - 85 * g8 + 128 * b8;
      cr = 128 * r8 - 107 * g8 - 21 * b8;
    end
    return {v, h, d, sat(y + 128), sat(cb + 32896), sat(cr + 32896)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    cur = '0;
    m_act = 1'b0;
    pv = 1'b0;
  endtask
  task automatic step(input logic c, input logic v, input logic h, input logic d,
                      input logic [4:0] r, input logic [5:0] g, input logic [4:0] b, input logic m);
    bus.ce = c;
    bus.pre_vsync = v;
    bus.pre_hsync = h;
    bus.pre_de = d;
    bus.img_r = r;
    bus.img_g = g;
    bus.img_b = b;
    bus.mode = m;
    if (c) begin
      q.push_back(model(r, g, b, m_act, v, h, d));
      if (v && !pv) m_act = EN ? m : 1'b0;
      pv = v;
    end
    @(posedge clk);
    #1;
    if (c) cur = q.pop_front();
    chk("pipe", {4'd0, obs}, {4'd0, cur, m_act});
  endtask
  task automatic px(input string tag, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    chk(tag, {8'd0, bus.img_y, bus.img_cb, bus.img_cr}, {8'd0, y, cb, cr});
  endtask
  initial begin
    bus.ce = 1'b0;
    bus.mode = 1'b0;
    bus.pre_vsync = 1'b0;
    bus.pre_hsync = 1'b0;
    bus.pre_de = 1'b0;
    bus.img_r = '0;
    bus.img_g = '0;
    bus.img_b = '0;
    model_reset();
    #3;
    chk("reset", {4'd0, obs}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1, 0, 0, 1, 5'd31, 6'd63, 5'd31, 0);
    px("white", 8'd255, 8'd128, 8'd128);
    repeat (3) step(1, 0, 0, 1, 5'd0, 6'd0, 5'd0, 0);
    px("black", 8'd0, 8'd128, 8'd128);
    repeat (3) step(1, 0, 0, 1, 5'd31, 6'd0, 5'd0, 0);
    px("red601", 8'd77, 8'd85, 8'd255);
    repeat (3) step(1, 0, 0, 1, 5'd0, 6'd0, 5'd31, 0);
    px("blue601", 8'd29, 8'd255, 8'd107);
    repeat (3) step(1, 0, 0, 1, 5'd31, 6'd0, 5'd0, 1);
    px("mode_midframe", 8'd77, 8'd85, 8'd255);
    chk("mode_act_hold", {31'd0, bus.mode_act}, 32'd0);
    step(1, 1, 0, 0, 5'd0, 6'd0, 5'd0, 1);
    step(1, 1, 0, 0, 5'd0, 6'd0, 5'd0, 1);
    repeat (3) step(1, 0, 0, 1, 5'd31, 6'd0, 5'd0, 0);
    if (EN) px("red709", 8'd54, 8'd99, 8'd255);
    else px("red_no709", 8'd77, 8'd85, 8'd255);
    chk("mode_act_frame", {31'd0, bus.mode_act}, {31'd0, EN});
    repeat (3) step(1, 0, 0, 1, 5'd31, 6'd0, 5'd0, 0);
    chk("mode_act_keep", {31'd0, bus.mode_act}, {31'd0, EN});
    step(1, 1, 0, 0, 5'd31, 6'd0, 5'd0, 0);
    repeat (4) step(1, 0, 0, 1, 5'd31, 6'd0, 5'd0, 0);
    px("red_back601", 8'd77, 8'd85, 8'd255);
    repeat (4) step(0, 1, 1, 0, 5'd7, 6'd9, 5'd3, 1);
    for (int i = 0; i < 400; i++) begin
      logic v, h;
      v = (i % 60) < 3;
      h = (i % 12) < 2;
      step(($urandom % 4) != 0, v, h, !v && !h, 5'($urandom), 6'($urandom), 5'($urandom), 1'($urandom));
    end
    repeat (3) step(1, 0, 0, 1, 5'd10, 6'd20, 5'd30, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_mid", {4'd0, obs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 1, 1, 5'd31, 6'd0, 5'd0, 0);
    step(1, 0, 1, 1, 5'd31, 6'd0, 5'd0, 0);
    chk("post_rst_zero", {4'd0, obs}, 32'd0);
    step(1, 0, 0, 0, 5'd0, 6'd0, 5'd0, 0);
    px("post_rst_first", 8'd77, 8'd85, 8'd255);
    chk("post_rst_sync", {29'd0, bus.post_vsync, bus.post_hsync, bus.post_de}, 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rgb2ycbcr_pipe.md
# rgb2ycbcr_pipe

Parametrised pipelined RGB-to-YCbCr converter for the HDMI video path, sitting between the camera/frame-buffer RGB output and the YCbCr-domain processing blocks (skin/colour detection, binarisation). Accepts RGB of configurable per-channel width, expands to 8 bits, and applies BT.601 or, optionally, BT.709 full-range coefficients with rounding and saturation. Video syncs are delayed to match data latency, and the whole pipeline supports a clock-enable stall. The coefficient set switches only at frame boundaries.

## Interface
- R_W, 5, input red width (4..8)
- G_W, 6, input green width (4..8)
- B_W, 5, input blue width (4..8)
- clk  input  1  pixel clock
- rst_n  input  1  reset, asynchronous, active-low
- ce  input  1  pipeline advance enable; low = hold all state
- mode  input  1  coefficient select, 0 = BT.601, 1 = BT.709; sampled per frame
- pre_vsync  input  1  input vsync (active-high)
- pre_hsync  input  1  input hsync
- pre_de  input  1  input data enable
- img_r  input  R_W  red
- img_g  input  G_W  green
- img_b  input  B_W  blue
- post_vsync  output  1  vsync delayed 3 ce-cycles
- post_hsync  output  1  hsync delayed 3 ce-cycles
- post_de  output  1  de delayed 3 ce-cycles
- img_y  output  8  luma
- img_cb  output  8  blue-difference chroma
- img_cr  output  8  red-difference chroma
- mode_act  output  1  coefficient set currently in use

## Operation
- Expansion: 8-bit channel = {x, x[W-1 -: 8-W]} (MSB replication); W=8 passes through.
- Coefficients (Q8): BT.601 Y=77R+150G+29B, Cb=-43R-85G+128B, Cr=128R-107G-21B; BT.709 Y=54R+183G+19B, Cb=-29R-99G+128B, Cr=128R-116G-12B.
- Stage 1: register nine products (unsigned 16 bit). Stage 2: signed 18-bit sums; chroma adds 32768; all three add 128 (round-half-up). Stage 3: take bits [15:8] after saturation: sum < 0 -> 0, sum > 65535 -> 255.
- Frame-locked mode: mode_act loads mode on the ce-cycle where pre_vsync rises (pre_vsync=1, previous registered pre_vsync=0). Stage-1 coefficients use mode_act; a frame never mixes coefficient sets.
- Sync path: 3-deep shift registers for vsync/hsync/de, advanced only when ce=1.
- Data outputs are not gated by de; blanking pixels are converted like any other.

## Timing
- Reset: all pipeline registers, img_y/img_cb/img_cr = 0, post_* = 0, mode_act = 0, vsync edge register = 0.
- Latency: exactly 3 cycles with ce held high; in general, output corresponds to the input sampled 3 ce=1 cycles earlier.
- ce=0: every register (data, syncs, mode_act, edge detector) holds; outputs stay constant; no edge is detected while stalled.
- Throughput: one pixel per ce=1 cycle, no bubbles.
- mode change with no vsync rise: no effect until next rising vsync.
- Reset asserted mid-frame: immediate clear; after release, first 3 ce-cycles output zeros and deasserted syncs.

## Configuration
- RGB2YCBCR_BT709_EN defined: mode input and BT.709 coefficient set compiled in, as above.
- Not defined: BT.601 only; mode ignored, mode_act tied 0, no BT.709 multipliers synthesised; results bit-identical to mode=0.

## Test plan
- White 565 (31,63,31), mode 0, ce=1 -> 3 cycles later Y=255, Cb=128, Cr=128; black (0,0,0) -> Y=0, Cb=128, Cr=128.
- Pure red (31,0,0), BT.601 -> Y=77, Cb=85, Cr=255 (saturated from 256); pure blue (0,0,31) -> Y=29, Cb=255 (saturated), Cr=107.
- Pure red with mode=1 set before a vsync rise (macro on) -> Y=54, Cb=99, Cr=255, mode_act=1; macro off -> BT.601 values, mode_act=0.
- Toggle mode mid-frame -> outputs keep old set until next vsync rise; then switch on the first pixel of the new frame.
- Pseudo-random ce pattern with pixel stream and de/hsync/vsync -> output sequence equals ce=1 reference model shifted 3 ce-cycles, syncs aligned with data.
- Assert rst_n low mid-line -> all outputs 0 at once; after release, first valid output 3 ce-cycles after first input.
